// File: rtl/timer_pkg.sv
// Shared definitions for the timer APB register slice: register addresses,
// register bit positions, handshake FSM state encoding and the
// address-error decode used by both the read and the write path.
package timer_pkg;

    // Register addresses
    localparam logic [7:0] ADDR_TDR  = 8'h00;
    localparam logic [7:0] ADDR_TCR  = 8'h01;
    localparam logic [7:0] ADDR_TSR  = 8'h02;
    localparam logic [7:0] ADDR_TIE  = 8'h03;
    localparam logic [7:0] ADDR_TCNT = 8'h04;

    // TCR bit positions
    localparam int TCR_EN     = 0;
    localparam int TCR_UP_DN  = 1;
    localparam int TCR_CKS_LO = 2;
    localparam int TCR_CKS_HI = 3;
    localparam int TCR_LOAD   = 7;

    // TSR / TIE bit positions (TIE enables line up with TSR flags)
    localparam int TSR_OVF    = 0;
    localparam int TSR_UDF    = 1;
    localparam int TIE_OVF_IE = 0;
    localparam int TIE_UDF_IE = 1;

    // APB handshake states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_WAIT  = 2'd2,
        ST_READY = 2'd3
    } apb_state_t;

    // Unmapped address, or a write to the read-only counter snapshot
    function automatic logic addr_error(input logic [7:0] addr, input logic write);
        return (addr > ADDR_TCNT) || (write && (addr == ADDR_TCNT));
    endfunction

endpackage

// File: rtl/timer_apb_fsm.sv
// APB handshake FSM for the timer register slice.
// Optional macro TIMER_APB_WAIT_EN: when defined, one wait state is inserted
// so pready is high in the second access cycle; when undefined, WAIT is
// skipped and pready is high in the first access cycle.
// SETUP is the bus setup cycle itself, recognised combinationally from IDLE
// with psel & !penable, so the registered state already holds WAIT/READY
// during the first access cycle.
module timer_apb_fsm
    import timer_pkg::*;
(
    input  logic cpu_clk,
    input  logic cpu_rstn,
    input  logic psel,
    input  logic penable,
    output logic pready,
    output logic commit,
    output logic rd_load
);

    apb_state_t r_state;
    apb_state_t w_cur;
    apb_state_t w_next;
    logic       r_pready;

    // Current phase (including the setup cycle) and next-state decode
    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        w_cur = r_state;
        if ((r_state == ST_IDLE) && psel && !penable) begin
            w_cur = ST_SETUP;
        end

        w_next = ST_IDLE;
        case (w_cur)
            ST_IDLE:  w_next = ST_IDLE;
`ifdef TIMER_APB_WAIT_EN
            ST_SETUP: w_next = ST_WAIT;
`else
            ST_SETUP: w_next = ST_READY;
`endif
            ST_WAIT:  w_next = ST_READY;
            ST_READY: w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase

        // Dropping psel abandons the transfer from any state
        if (!psel) begin
            w_next = ST_IDLE;
        end
    end

    // State register with registered pready
    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            r_state  <= ST_IDLE;
            r_pready <= 1'b0;
        end else begin
            // NOTE: flops use non-blocking assignments so every flop samples pre-edge values.
            r_state  <= w_next;
            r_pready <= (w_next == ST_READY);
        end
    end

    assign pready  = r_pready;
    // Writes commit on the edge that ends the READY cycle
    assign commit  = r_pready;
    // Read data is captured on the edge that enters READY
    assign rd_load = (w_next == ST_READY);

endmodule

// File: rtl/timer_apb_regs.sv
// APB register file for a simple 8-bit timer: TDR reload, TCR control with
// a self-clearing load strobe, W1C status flags with set-priority, interrupt
// enables and a read-only counter snapshot.
// Optional macro TIMER_APB_WAIT_EN (in timer_apb_fsm) adds one APB wait state.
module timer_apb_regs
    import timer_pkg::*;
(
    input  logic       cpu_clk,
    input  logic       cpu_rstn,
    input  logic       psel,
    input  logic       penable,
    input  logic       pwrite,
    input  logic [7:0] paddr,
    input  logic [7:0] pwdata,
    output logic [7:0] prdata,
    output logic       pready,
    output logic       pslverr,
    input  logic [7:0] cnt_in,
    input  logic       ovf_set,
    input  logic       udf_set,
    output logic [7:0] tdr,
    output logic       en,
    output logic       up_dn,
    output logic [1:0] cks,
    output logic       load_pulse,
    output logic       irq
);

    logic       w_commit;
    logic       w_rd_load;
    logic       w_err;
    logic       w_wr;
    logic [7:0] w_rdata;
    logic [1:0] w_tsr_set;
    logic [1:0] w_tsr_clr;

    logic [7:0] r_tdr;
    logic [3:0] r_tcr;
    logic [1:0] r_tsr;
    logic [1:0] r_tie;
    logic       r_load;
    logic [7:0] r_prdata;
    logic       r_pslverr;

    timer_apb_fsm u_fsm (
        .cpu_clk  (cpu_clk),
        .cpu_rstn (cpu_rstn),
        .psel     (psel),
        .penable  (penable),
        .pready   (pready),
        .commit   (w_commit),
        .rd_load  (w_rd_load)
    );

    assign w_err = addr_error(paddr, pwrite);
    assign w_wr  = w_commit && pwrite && !w_err;

    // Read mux; unused bits read as zero
    always_comb begin
        w_rdata = 8'h00;
        case (paddr)
            ADDR_TDR:  w_rdata = r_tdr;
            ADDR_TCR:  w_rdata = {4'b0000, r_tcr};
            ADDR_TSR:  w_rdata = {6'b000000, r_tsr};
            ADDR_TIE:  w_rdata = {6'b000000, r_tie};
            ADDR_TCNT: w_rdata = cnt_in;
            default:   w_rdata = 8'h00;
        endcase
    end

    // Status flag set/clear terms; a coincident set overrides the W1C clear
    assign w_tsr_set[TSR_OVF] = ovf_set;
    assign w_tsr_set[TSR_UDF] = udf_set;
    assign w_tsr_clr = (w_wr && (paddr == ADDR_TSR)) ? pwdata[1:0] : 2'b00;

    // Control/status registers and the load strobe
    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            r_tdr  <= 8'h00;
            r_tcr  <= 4'h0;
            r_tsr  <= 2'b00;
            r_tie  <= 2'b00;
            r_load <= 1'b0;
        end else begin
            r_tsr  <= (r_tsr & ~w_tsr_clr) | w_tsr_set;
            r_load <= w_wr && (paddr == ADDR_TCR) && pwdata[TCR_LOAD];
            if (w_wr) begin
                case (paddr)
                    ADDR_TDR: r_tdr <= pwdata;
                    ADDR_TCR: r_tcr <= pwdata[TCR_CKS_HI:TCR_EN];
                    ADDR_TIE: r_tie <= pwdata[TIE_UDF_IE:TIE_OVF_IE];
                    default:  ;
                endcase
            end
        end
    end

    // Read data and error response, captured on entry to READY
    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            r_prdata  <= 8'h00;
            r_pslverr <= 1'b0;
        end else begin
            r_pslverr <= w_rd_load && w_err;
            if (w_rd_load) begin
                r_prdata <= w_err ? 8'h00 : w_rdata;
            end
        end
    end

    assign prdata     = r_prdata;
    assign pslverr    = r_pslverr;
    assign tdr        = r_tdr;
    assign en         = r_tcr[TCR_EN];
    assign up_dn      = r_tcr[TCR_UP_DN];
    assign cks        = r_tcr[TCR_CKS_HI:TCR_CKS_LO];
    assign load_pulse = r_load;
    assign irq        = |(r_tsr & r_tie);

endmodule

// File: tb/tb_timer_apb_regs.sv
// Directed bench for timer_apb_regs: a vector table of APB transfers plus
// hand-written sequences for load strobe, W1C/set priority and mid-transfer
// reset. Expected access latency follows TIMER_APB_WAIT_EN.
module tb_timer_apb_regs;

`ifdef TIMER_APB_WAIT_EN
    localparam int EXP_LAT = 2;
`else
    localparam int EXP_LAT = 1;
`endif

    logic       cpu_clk = 1'b0;
    logic       cpu_rstn;
    logic       psel, penable, pwrite;
    logic [7:0] paddr, pwdata;
    logic [7:0] prdata;
    logic       pready, pslverr;
    logic [7:0] cnt_in;
    logic       ovf_set, udf_set;
    logic [7:0] tdr;
    logic       en, up_dn;
    logic [1:0] cks;
    logic       load_pulse, irq;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rd;
        logic       exp_err;
    } vec_t;

    vec_t vecs[16];

    timer_apb_regs dut (
        .cpu_clk    (cpu_clk),
        .cpu_rstn   (cpu_rstn),
        .psel       (psel),
        .penable    (penable),
        .pwrite     (pwrite),
        .paddr      (paddr),
        .pwdata     (pwdata),
        .prdata     (prdata),
        .pready     (pready),
        .pslverr    (pslverr),
        .cnt_in     (cnt_in),
        .ovf_set    (ovf_set),
        .udf_set    (udf_set),
        .tdr        (tdr),
        .en         (en),
        .up_dn      (up_dn),
        .cks        (cks),
        .load_pulse (load_pulse),
        .irq        (irq)
    );

    always #5 cpu_clk = ~cpu_clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    // One APB transfer; returns read data, error and the access cycle in
    // which pready was seen (0 = never within the budget).
    task automatic apb(input logic wr, input logic [7:0] a, input logic [7:0] d,
                       input logic ovf_in_ready,
                       output logic [7:0] rd, output logic err, output int lat);
        lat = 0;
        rd  = 8'h00;
        err = 1'b0;
        @(negedge cpu_clk);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        @(negedge cpu_clk);
        penable = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            if (pready === 1'b1) begin
                lat = k;
                break;
            end
            @(negedge cpu_clk);
        end
        if (lat != 0) begin
            rd  = prdata;
            err = pslverr;
            if (ovf_in_ready) ovf_set = 1'b1;
            @(negedge cpu_clk);
            ovf_set = 1'b0;
            check("pready_single_cycle", {7'b0, pready}, 8'h00);
        end
        // Idle bus with junk address/data that must be ignored
        psel = 1'b0; penable = 1'b0; pwrite = 1'b1; paddr = 8'h02; pwdata = 8'hFF;
    endtask

    task automatic do_read(input logic [7:0] a, input logic [7:0] exp, input string name);
        logic [7:0] rd;
        logic       err;
        int         lat;
        apb(1'b0, a, 8'h00, 1'b0, rd, err, lat);
        check({name, "_lat"}, 8'(lat), 8'(EXP_LAT));
        check({name, "_rd"}, rd, exp);
        check({name, "_err"}, {7'b0, err}, 8'h00);
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d, input logic ovf_in_ready);
        logic [7:0] rd;
        logic       err;
        int         lat;
        apb(1'b1, a, d, ovf_in_ready, rd, err, lat);
        check("wr_lat", 8'(lat), 8'(EXP_LAT));
        check("wr_err", {7'b0, err}, 8'h00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd;
        logic       err;
        int         lat;

        //           wr    addr   wdata  exp_rd exp_err
        vecs[0]  = '{1'b1, 8'h00, 8'hA5, 8'h00, 1'b0};
        vecs[1]  = '{1'b0, 8'h00, 8'h00, 8'hA5, 1'b0};
        vecs[2]  = '{1'b1, 8'h01, 8'h87, 8'h00, 1'b0};
        vecs[3]  = '{1'b0, 8'h01, 8'h00, 8'h07, 1'b0};
        vecs[4]  = '{1'b1, 8'h03, 8'h01, 8'h00, 1'b0};
        vecs[5]  = '{1'b0, 8'h03, 8'h00, 8'h01, 1'b0};
        vecs[6]  = '{1'b0, 8'h09, 8'h00, 8'h00, 1'b1};
        vecs[7]  = '{1'b1, 8'h04, 8'h33, 8'h00, 1'b1};
        vecs[8]  = '{1'b0, 8'h00, 8'h00, 8'hA5, 1'b0};
        vecs[9]  = '{1'b0, 8'h04, 8'h00, 8'h3C, 1'b0};
        vecs[10] = '{1'b1, 8'h05, 8'h11, 8'h00, 1'b1};
        vecs[11] = '{1'b1, 8'h01, 8'hF8, 8'h00, 1'b0};
        vecs[12] = '{1'b0, 8'h01, 8'h00, 8'h08, 1'b0};
        vecs[13] = '{1'b1, 8'h03, 8'hFE, 8'h00, 1'b0};
        vecs[14] = '{1'b0, 8'h03, 8'h00, 8'h02, 1'b0};
        vecs[15] = '{1'b0, 8'h02, 8'h00, 8'h00, 1'b0};

        cpu_rstn = 1'b0;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 8'h00; pwdata = 8'h00;
        cnt_in = 8'h3C; ovf_set = 1'b0; udf_set = 1'b0;
        repeat (3) @(negedge cpu_clk);

        // Reset state
        check("rst_prdata", prdata, 8'h00);
        check("rst_pready", {7'b0, pready}, 8'h00);
        check("rst_pslverr", {7'b0, pslverr}, 8'h00);
        check("rst_load_pulse", {7'b0, load_pulse}, 8'h00);
        check("rst_irq", {7'b0, irq}, 8'h00);
        check("rst_tdr", tdr, 8'h00);
        check("rst_ctrl", {3'b0, cks, up_dn, en}, 8'h00);
        cpu_rstn = 1'b1;
        @(negedge cpu_clk);

        // Table-driven transfers
        for (int i = 0; i < 16; i++) begin
            apb(vecs[i].wr, vecs[i].addr, vecs[i].wdata, 1'b0, rd, err, lat);
            check($sformatf("vec%0d_lat", i), 8'(lat), 8'(EXP_LAT));
            check($sformatf("vec%0d_err", i), {7'b0, err}, {7'b0, vecs[i].exp_err});
            if (!vecs[i].wr) check($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
        end
        check("tdr_after_table", tdr, 8'hA5);

        // Load strobe: one cycle, the cycle after the commit edge
        do_write(8'h01, 8'h87, 1'b0);
        check("ctrl_after_87", {3'b0, cks, up_dn, en}, 8'b0000_0111);
        check("load_pulse_high", {7'b0, load_pulse}, 8'h01);
        @(negedge cpu_clk);
        check("load_pulse_low", {7'b0, load_pulse}, 8'h00);
        do_write(8'h01, 8'h07, 1'b0);
        check("no_load_without_bit7", {7'b0, load_pulse}, 8'h00);

        // Status flags, interrupt and W1C with set priority
        do_write(8'h03, 8'h01, 1'b0);
        check("irq_idle", {7'b0, irq}, 8'h00);
        @(negedge cpu_clk); ovf_set = 1'b1;
        @(negedge cpu_clk); ovf_set = 1'b0;
        check("irq_ovf", {7'b0, irq}, 8'h01);
        do_read(8'h02, 8'h01, "tsr_ovf");
        do_write(8'h02, 8'h01, 1'b0);
        check("irq_cleared", {7'b0, irq}, 8'h00);
        do_read(8'h02, 8'h00, "tsr_w1c");
        @(negedge cpu_clk); ovf_set = 1'b1;
        @(negedge cpu_clk); ovf_set = 1'b0;
        do_write(8'h02, 8'h01, 1'b1);
        do_read(8'h02, 8'h01, "tsr_set_wins");
        check("irq_set_wins", {7'b0, irq}, 8'h01);
        do_write(8'h02, 8'h03, 1'b0);
        @(negedge cpu_clk); udf_set = 1'b1;
        @(negedge cpu_clk); udf_set = 1'b0;
        check("irq_udf_masked", {7'b0, irq}, 8'h00);
        do_read(8'h02, 8'h02, "tsr_udf");

        // Reset in the middle of a write of 0xFF to TDR
        @(negedge cpu_clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 8'hFF;
        @(negedge cpu_clk);
        penable = 1'b1;
        cpu_rstn = 1'b0;
        #1;
        check("midrst_pready", {7'b0, pready}, 8'h00);
        check("midrst_tdr", tdr, 8'h00);
        check("midrst_prdata", prdata, 8'h00);
        @(negedge cpu_clk);
        psel = 1'b0; penable = 1'b0;
        @(negedge cpu_clk);
        cpu_rstn = 1'b1;
        check("postrst_tdr", tdr, 8'h00);
        do_read(8'h00, 8'h00, "postrst_tdr_rd");
        do_read(8'h01, 8'h00, "postrst_tcr_rd");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/timer_apb_regs.md
TIMER_APB_REGS -- requirements
Module: timer_apb_regs

Interface
REQ-001 SHALL provide: cpu_clk  input  1  single clock; all flops on rising edge.
REQ-002 SHALL provide: cpu_rstn  input  1  asynchronous, active-low reset.
REQ-003 SHALL provide: psel  input  1  APB slave select.
REQ-004 SHALL provide: penable  input  1  APB access phase.
REQ-005 SHALL provide: pwrite  input  1  1 = write, 0 = read.
REQ-006 SHALL provide: paddr  input  8  register address.
REQ-007 SHALL provide: pwdata  input  8  write data.
REQ-008 SHALL provide: prdata  output  8  read data, registered, valid while pready = 1.
REQ-009 SHALL provide: pready  output  1  transfer complete.
REQ-010 SHALL provide: pslverr  output  1  error, valid only with pready.
REQ-011 SHALL provide: cnt_in  input  8  live counter value from the timer core.
REQ-012 SHALL provide: ovf_set and udf_set  input  1 each  one-cycle event pulses from the core.
REQ-013 SHALL provide: tdr  output  8  reload value to the core.
REQ-014 SHALL provide: en, up_dn  output  1 each  count enable and count direction (1 = up).
REQ-015 SHALL provide: cks  output  2  clock-divider select.
REQ-016 SHALL provide: load_pulse  output  1  one-cycle strobe to load tdr into the counter.
REQ-017 SHALL provide: irq  output  1  interrupt, level.

Function
REQ-018 Register map SHALL be:
- 0x00 TDR: RW.
- 0x01 TCR: RW; [0] en, [1] up_dn, [3:2] cks, [7] load (write-1 pulse, reads 0); [6:4] read 0.
- 0x02 TSR: [0] ovf, [1] udf; W1C.
- 0x03 TIE: [0] ovf_ie, [1] udf_ie.
- 0x04 TCNT: RO, returns cnt_in.
REQ-019 Handshake FSM SHALL have states IDLE, SETUP, WAIT, READY.
- IDLE -> SETUP: psel & !penable.
- SETUP -> WAIT: penable.
- WAIT -> READY: unconditional.
- READY -> IDLE: unconditional.
- Any state -> IDLE: psel = 0.
REQ-020 pready SHALL be 1 only in READY, i.e. exactly one cycle, the second access cycle.
REQ-021 Register writes SHALL commit at the clock edge ending READY when pwrite = 1; prdata SHALL be loaded on entry to READY.
REQ-022 An address > 0x04, or a write to 0x04, SHALL give pslverr = 1 with pready, prdata = 0x00, and no state change.
REQ-023 Writing TCR[7] = 1 SHALL raise load_pulse for exactly one cycle, the cycle after the commit edge.
REQ-024 The TSR bit update SHALL be evaluated in this order:
- ovf_set or udf_set sets its bit.
- A W1C write of 1 clears its bit.
- When set and clear occur in the same cycle, set SHALL win.
REQ-025 irq SHALL equal |(TSR[1:0] & TIE[1:0]), combinational from flops.
REQ-026 Unused bits SHALL read 0 and ignore writes; paddr/pwdata changes outside SETUP..READY SHALL have no effect.

Reset
REQ-027 cpu_rstn = 0 SHALL asynchronously force:
- All registers to 0x00.
- FSM to IDLE.
- prdata = 0x00; pready, pslverr, load_pulse, irq = 0.
REQ-028 Reset mid-transfer SHALL abort it without committing any write; after release the slave SHALL accept a new SETUP.

Configuration
REQ-029 With TIMER_APB_WAIT_EN defined, the FSM SHALL operate as in REQ-019/020 (one wait state).
REQ-030 Without TIMER_APB_WAIT_EN, WAIT SHALL be skipped (SETUP -> READY), so pready = 1 in the first access cycle; all other behaviour SHALL be unchanged.

Structure
REQ-031 A shared package timer_pkg SHALL hold:
- The register address constants (ADDR_TDR..ADDR_TCNT).
- The TCR/TSR/TIE bit positions.
- The FSM state encoding.
REQ-032 The handshake FSM SHALL be a sub-module, timer_apb_fsm, with outputs pready and a commit strobe; the register file SHALL remain in timer_apb_regs.

Verification
REQ-033 The bench SHALL cover these directed scenarios (stimulus -> required response):
- Write 0xA5 to 0x00, then read 0x00 -> prdata = 0xA5, pslverr = 0, pready high exactly one cycle, in the second access cycle (macro on).
- Write 0x87 to 0x01 -> en = 1, up_dn = 1, cks = 01, load_pulse single cycle; read 0x01 -> 0x07.
- Pulse ovf_set with TIE = 0x01 -> TSR = 0x01, irq = 1; write 0x01 to 0x02 -> TSR = 0x00, irq = 0; ovf_set coincident with the W1C commit -> TSR stays 0x01.
- Read 0x09 -> pslverr = 1, prdata = 0x00; write 0x33 to 0x04 -> pslverr = 1, registers unchanged.
- Assert cpu_rstn = 0 in WAIT of a write of 0xFF to 0x00 -> TDR = 0x00, pready = 0; the next read of 0x00 returns 0x00.
- Macro off, read 0x04 with cnt_in = 0x3C -> pready in the first access cycle, prdata = 0x3C.
